// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding,
// frame header width and bytes per instruction word.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    // States that accept stream bytes; these are also exactly the busy states.
    function automatic logic is_receiving(input state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs stream bytes MSB-first into 32-bit words and keeps the running XOR
// of every data byte seen since the last clear.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word,
    output logic [7:0]  acc
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;

    // Next-state for the shift register, byte counter and XOR accumulator.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (clr) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
            acc_d   = 8'd0;
        end else if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
            acc_d   = acc_q ^ byte_in;
        end else begin
            cnt_d   = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
            acc_q   <= 8'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // The word completes on the fourth byte; the top level registers it.
    assign word_done = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word      = {shift_q, byte_in};
    assign acc       = acc_q;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length-prefixed byte frame, writes big-endian words
// into instruction RAM from address 0 and releases the CPU on a good checksum.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [HDR_W:0] MAX_WORDS = (HDR_W + 1)'(2 ** ADDR_W);

    state_t             state_q, state_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W:0]    n_q, n_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    words_q, words_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_run_q, cpu_run_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               hs_s, clr_s, data_hs_s, word_done_s;
    logic [31:0]        word_s;
    logic [7:0]         acc_s;
    logic [HDR_W-1:0]   n_s;
    logic [ADDR_W:0]    words_inc_s;

    assign rx_ready    = is_receiving(state_q);
    assign hs_s        = rx_valid && rx_ready;
    assign data_hs_s   = hs_s && (state_q == S_DATA);
    assign n_s         = {hi_q, rx_data};
    assign words_inc_s = words_q + (ADDR_W + 1)'(1);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_s),
        .byte_valid (data_hs_s),
        .byte_in    (rx_data),
        .word_done  (word_done_s),
        .word       (word_s),
        .acc        (acc_s)
    );

    // Frame FSM, address/word counters and the RAM write port next-state.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        n_d         = n_q;
        addr_d      = addr_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        err_d       = err_q;
        clr_s       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_HDR_HI;
                    cpu_run_d = 1'b0;
                    err_d     = 1'b0;
                    words_d   = '0;
                    addr_d    = '0;
                    clr_s     = 1'b1;
                end else begin
                    state_d   = state_q;
                end
            end
            S_HDR_HI: begin
                if (hs_s) begin
                    hi_d    = rx_data;
                    state_d = S_HDR_LO;
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_LO: begin
                if (!hs_s) begin
                    state_d = state_q;
                end else if ({1'b0, n_s} > MAX_WORDS) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    n_d     = n_s[ADDR_W:0];
                    state_d = (n_s == HDR_W'(0)) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (word_done_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = word_s;
                    addr_d      = addr_q + ADDR_W'(1);
                    words_d     = words_inc_s;
                    state_d     = (words_inc_s == n_q) ? S_CSUM : S_DATA;
                end else begin
                    state_d     = state_q;
                end
            end
            S_CSUM: begin
                if (!hs_s) begin
                    state_d   = state_q;
                end else if (rx_data == acc_s) begin
                    state_d   = S_DONE;
                    cpu_run_d = 1'b1;
                end else begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = is_receiving(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hi_q        <= 8'd0;
            n_q         <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_run_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed vector table, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_instr_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frm [0:1039];
    int          frm_len;
    logic [39:0] wq [$];

    logic [31:0] exp_w [0:255];
    int          m_nw;
    bit          m_run, m_err;
    int          m_words;

    typedef struct {
        int         len;
        logic [7:0] b [13];
        bit         gap;
        int         start_at;
        bit         exp_run;
        bit         exp_err;
        int         exp_words;
    } vec_t;

    vec_t tbl [7];

    // Record every RAM write seen at the falling edge.
    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: header length, big-endian words, XOR checksum.
    task automatic model();
        int n;
        logic [7:0] x;
        n = {frm[0], frm[1]};
        x = 8'd0;
        if (n > 256) begin
            m_nw = 0; m_words = 0; m_run = 0; m_err = 1;
        end else begin
            m_nw = n; m_words = n;
            for (int i = 0; i < n; i++) begin
                exp_w[i] = {frm[2+4*i], frm[3+4*i], frm[4+4*i], frm[5+4*i]};
                for (int k = 0; k < 4; k++) x = x ^ frm[2+4*i+k];
            end
            m_run = (frm[2+4*n] == x);
            m_err = !m_run;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input bit gap, input int start_at);
        int t;
        for (int i = 0; i < frm_len; i++) begin
            if (gap) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = frm[i];
            if (i == start_at) start = 1'b1;
            t = 0;
            while (!rx_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!rx_ready) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: got 0 expected 1 at byte %0d", i);
                rx_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_end(input bit e_run, input bit e_err, input int e_words);
        chk("cpu_run", cpu_run, e_run);
        chk("err", err, e_err);
        chk("words_loaded", words_loaded, e_words);
        chk("busy_end", busy, 1'b0);
        chk("rx_ready_end", rx_ready, 1'b0);
        chk("n_writes", wq.size(), m_nw);
        for (int i = 0; i < m_nw && i < wq.size(); i++) begin
            chk("wr_addr", wq[i][39:32], i);
            chk("wr_data", wq[i][31:0], exp_w[i]);
        end
    endtask

    task automatic run_case(input bit gap, input int start_at,
                            input bit e_run, input bit e_err, input int e_words);
        model();
        wq.delete();
        do_start();
        chk("busy_after_start", busy, 1'b1);
        chk("run_clear_after_start", cpu_run, 1'b0);
        feed(gap, start_at);
        check_end(e_run, e_err, e_words);
    endtask

    task automatic load_vec(input int idx);
        frm_len = tbl[idx].len;
        for (int i = 0; i < tbl[idx].len; i++) frm[i] = tbl[idx].b[i];
    endtask

    initial begin
        logic [7:0] nom [13];
        int n;
        logic [7:0] x;

        nom = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'hAC, 8'h08, 8'h00, 8'h00, 8'h89, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            tbl[i].b = nom; tbl[i].len = 11; tbl[i].gap = 0; tbl[i].start_at = -1;
            tbl[i].exp_run = 1; tbl[i].exp_err = 0; tbl[i].exp_words = 2;
        end
        tbl[1].b[10] = 8'h88; tbl[1].exp_run = 0; tbl[1].exp_err = 1;
        tbl[2].b[1] = 8'h00; tbl[2].b[2] = 8'h00; tbl[2].len = 3; tbl[2].exp_words = 0;
        tbl[3].b[0] = 8'h01; tbl[3].b[1] = 8'h01; tbl[3].len = 2;
        tbl[3].exp_run = 0; tbl[3].exp_err = 1; tbl[3].exp_words = 0;
        tbl[4].gap = 1;
        tbl[5].start_at = 5;
        tbl[6].b[1] = 8'h01; tbl[6].b[2] = 8'hDE; tbl[6].b[3] = 8'hAD;
        tbl[6].b[4] = 8'hBE; tbl[6].b[5] = 8'hEF; tbl[6].b[6] = 8'h22;
        tbl[6].len = 7; tbl[6].exp_words = 1;

        // Reset with rx_valid asserted.
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_run", cpu_run, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_words", words_loaded, 0);
        rst_n = 1'b1;
        wq.delete();
        repeat (4) begin
            @(negedge clk);
            chk("idle_rx_ready", rx_ready, 1'b0);
        end
        chk("idle_no_write", wq.size(), 0);
        chk("idle_busy", busy, 1'b0);
        rx_valid = 1'b0;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            run_case(tbl[v].gap, tbl[v].start_at, tbl[v].exp_run, tbl[v].exp_err, tbl[v].exp_words);
        end

        // Start in DONE drops cpu_run next cycle and a reload runs.
        load_vec(0);
        run_case(1'b0, -1, 1'b1, 1'b0, 2);
        wq.delete();
        do_start();
        chk("restart_run_drop", cpu_run, 1'b0);
        chk("restart_busy", busy, 1'b1);
        chk("restart_words", words_loaded, 0);
        feed(1'b0, -1);
        check_end(1'b1, 1'b0, 2);

        // Reset after two data bytes of word 0.
        frm[0] = 8'h00; frm[1] = 8'h01; frm[2] = 8'hAA; frm[3] = 8'hBB; frm_len = 4;
        wq.delete();
        do_start();
        feed(1'b0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rx_ready", rx_ready, 1'b0);
        chk("midrst_words", words_loaded, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", wq.size(), 0);
        chk("midrst_idle", rx_ready, 1'b0);
        load_vec(0);
        run_case(1'b0, -1, 1'b1, 1'b0, 2);

        // Full-capacity frame: N == 2^ADDR_W.
        frm[0] = 8'h01; frm[1] = 8'h00;
        x = 8'd0;
        for (int i = 0; i < 1024; i++) begin
            frm[2+i] = 8'($urandom);
            x = x ^ frm[2+i];
        end
        frm[1026] = x;
        frm_len = 1027;
        run_case(1'b0, -1, 1'b1, 1'b0, 256);

        // Random frames against the model.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(257, 65535);
                frm[0] = n[15:8]; frm[1] = n[7:0];
                frm_len = 2;
            end else begin
                n = $urandom_range(0, 6);
                frm[0] = 8'd0; frm[1] = n[7:0];
                x = 8'd0;
                for (int i = 0; i < 4*n; i++) begin
                    frm[2+i] = 8'($urandom);
                    x = x ^ frm[2+i];
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                frm[2+4*n] = x;
                frm_len = 3 + 4*n;
            end
            model();
            run_case(1'($urandom_range(0, 1)), -1, m_run, m_err, m_words);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader that sits directly upstream of the single-cycle CPU's instruction memory. It receives a framed byte stream over a valid/ready byte interface, assembles big-endian 32-bit instruction words and writes them sequentially into instruction RAM from word address 0. It verifies a trailing XOR checksum, then releases the CPU by asserting `cpu_run`. While `cpu_run` is low the CPU and its PC register are held in reset.

## Interface
- `ADDR_W`, 8: instruction RAM word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled in IDLE, DONE and ERR; ignored otherwise.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle instruction-RAM write strobe.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  instruction word.
- `cpu_run`  out  1  load succeeded; CPU may execute.
- `busy`  out  1  load in progress (states HDR_HI through CSUM).
- `err`  out  1  load failed (state ERR).
- `words_loaded`  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- Frame format: N[15:8], N[7:0], then 4·N data bytes, then 1 checksum byte. The checksum is the XOR of all data bytes; header bytes are excluded.
- A handshake occurs when `rx_valid && rx_ready`. `rx_ready` = 1 only in HDR_HI, HDR_LO, DATA and CSUM.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
  - IDLE, DONE or ERR with `start` → HDR_HI. This clears `cpu_run`, `err`, `words_loaded`, the byte counter, the word address and the checksum accumulator.
  - HDR_HI with handshake → HDR_LO (latch N[15:8]).
  - HDR_LO with handshake, depending on N:
    - N > 2^ADDR_W → ERR.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: on each handshake, shift the byte in MSB-first (first byte → `[31:24]`) and XOR it into the accumulator. On the 4th byte of a word, schedule a write. After the last byte of word N-1 → CSUM.
  - CSUM with handshake → DONE if the byte equals the accumulator, else ERR.
  - DONE and ERR hold until `start` or reset.
- Writes go to addresses 0, 1, …, N-1. The address increments after each write. `words_loaded` increments on each `mem_we`.
- N == 2^ADDR_W is legal. The last write goes to address 2^ADDR_W−1, and the address counter wraps to 0 unused.
- `start` while busy is ignored. `rx_valid` outside the receiving states is ignored because no handshake occurs.
- Reset mid-load returns to IDLE and discards any partial word. RAM contents are not cleared. A new `start` is required.

## Timing
- Reset values: `rx_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_run`, `busy`, `err` and `words_loaded` are all 0. State is IDLE.
- All outputs are registered except `rx_ready`, which is decoded from the registered state only and has no combinational path from `rx_valid`.
- Throughput: one byte per cycle. There is no stall on RAM writes.
- `mem_we` is high for exactly one cycle, the cycle after the 4th byte's handshake, with `mem_addr` and `mem_wdata` valid in that same cycle.
- `cpu_run` rises the cycle after a matching checksum handshake. It is level-held.
- `err` rises the cycle after the failing handshake (header or checksum). It is level-held.
- `busy` goes high the cycle after `start` is sampled. It drops in the same cycle `cpu_run` or `err` rises.

## Structure
- Shared package `instr_loader_pkg` holds:
  - the FSM state encoding (3-bit, 7 states);
  - the header width (16);
  - the byte count per word (4).
- One sub-module, `word_assembler`:
  - 4-byte shift register and 2-bit byte counter;
  - XOR accumulator;
  - outputs a `word_done` pulse and the assembled word.
- The top level holds the FSM, the address and word counters, and the registered RAM write port.

## Test plan
- **Reset:** hold `rst_n`=0 with `rx_valid`=1 → all outputs 0, `rx_ready`=0. After release with no `start`, there are no handshakes.
- **Nominal 2-word load:**
  - Stimulus: `start`, then bytes 00 02 | 20 08 00 05 | AC 08 00 00 | 89.
  - Expect `mem_we` at addr 0 with 0x20080005, then at addr 1 with 0xAC080000.
  - Expect `cpu_run`=1, `words_loaded`=2, `err`=0.
- **Bad checksum:** same frame with final byte 0x88 → both writes occur, `err`=1, `cpu_run`=0, `words_loaded`=2.
- **Empty frame:** 00 00 00 → DONE with `cpu_run`=1 and no `mem_we` pulse. Oversize header 01 01 with ADDR_W=8 → ERR, no writes, `rx_ready`=0.
- **Backpressure and restart:**
  - Drive `rx_valid` on alternate cycles for the nominal frame → identical writes and `cpu_run`.
  - Pulse `start` mid-DATA → no effect.
  - Pulse `start` in DONE → `cpu_run` drops next cycle and a reload runs.
- **Reset mid-load:** assert `rst_n`=0 after 2 data bytes of word 0 → IDLE with no `mem_we`. A fresh nominal frame then loads correctly.
